// File: rtl/mult8x8_sequencer_pkg.sv
// Shared types and encodings for the sequential 8x8 multiplier controller.
// Holds the state enum plus mux-select, shift and display constants.
package mult_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LSB  = 3'd1,
    S_MID1 = 3'd2,
    S_MID2 = 3'd3,
    S_MSB  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  localparam logic [1:0] SEL_LL = 2'b00;
  localparam logic [1:0] SEL_LH = 2'b01;
  localparam logic [1:0] SEL_HL = 2'b10;
  localparam logic [1:0] SEL_HH = 2'b11;

  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH4 = 2'b01;
  localparam logic [1:0] SH8 = 2'b10;

  localparam logic [2:0] DISP_IDLE = 3'd0;
  localparam logic [2:0] DISP_LSB  = 3'd1;
  localparam logic [2:0] DISP_MID  = 3'd2;
  localparam logic [2:0] DISP_MSB  = 3'd3;
  localparam logic [2:0] DISP_ERR  = 3'd4;

endpackage

// File: rtl/mult8x8_sequencer.sv
// Control FSM stepping a shared 4x4 multiplier through four partial products.
// Moore outputs from the state register; en=0 freezes state and masks accumulator strobes.
module mult8x8_sequencer
  import mult_seq_pkg::*;
#(
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       en,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state_out
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   start_acc;

  assign start_acc = en && start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        S_IDLE:  state_d = start ? S_LSB : S_IDLE;
        S_LSB:   state_d = start ? S_ERR : S_MID1;
        S_MID1:  state_d = start ? S_ERR : S_MID2;
        S_MID2:  state_d = start ? S_ERR : S_MSB;
        S_MSB:   state_d = start ? S_ERR : S_DONE;
        S_DONE:  state_d = start ? S_LSB : S_IDLE;
        S_ERR:   state_d = start ? S_ERR : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sticky completion flag, only observed when DONE_HOLD is set.
  always_comb begin
    done_d = done_q;
    if (start_acc || (state_d == S_ERR && state_q != S_ERR))
      done_d = 1'b0;
    if (state_d == S_DONE && state_q != S_DONE)
      done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    input_sel = SEL_LL;
    shift_sel = SH0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    state_out = DISP_IDLE;
    case (state_q)
      S_LSB: begin
        acc_clr   = en;
        state_out = DISP_LSB;
      end
      S_MID1: begin
        input_sel = SEL_LH;
        shift_sel = SH4;
        acc_en    = en;
        state_out = DISP_MID;
      end
      S_MID2: begin
        input_sel = SEL_HL;
        shift_sel = SH4;
        acc_en    = en;
        state_out = DISP_MID;
      end
      S_MSB: begin
        input_sel = SEL_HH;
        shift_sel = SH8;
        acc_en    = en;
        state_out = DISP_MSB;
      end
      S_ERR:   state_out = DISP_ERR;
      default: state_out = DISP_IDLE;
    endcase
  end

  assign busy = (state_q == S_LSB) || (state_q == S_MID1) ||
                (state_q == S_MID2) || (state_q == S_MSB);
  assign err  = (state_q == S_ERR);
  assign done = DONE_HOLD ? done_q : (state_q == S_DONE);

endmodule

// File: tb/tb_mult8x8_sequencer.sv
// Directed bench for mult8x8_sequencer with a reference shift/accumulate datapath.
// Runs a pulse-done and a sticky-done instance side by side on shared inputs.
module tb_mult8x8_sequencer;

  logic clk, reset, start, en;
  logic [1:0] input_sel, shift_sel, h_input_sel, h_shift_sel;
  logic acc_clr, acc_en, busy, done, err;
  logic h_acc_clr, h_acc_en, h_busy, h_done, h_err;
  logic [2:0] state_out, h_state_out;

  mult8x8_sequencer #(.DONE_HOLD(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .en(en),
    .input_sel(input_sel), .shift_sel(shift_sel), .acc_clr(acc_clr), .acc_en(acc_en),
    .busy(busy), .done(done), .err(err), .state_out(state_out)
  );

  mult8x8_sequencer #(.DONE_HOLD(1'b1)) dut_h (
    .clk(clk), .reset(reset), .start(start), .en(en),
    .input_sel(h_input_sel), .shift_sel(h_shift_sel), .acc_clr(h_acc_clr), .acc_en(h_acc_en),
    .busy(h_busy), .done(h_done), .err(h_err), .state_out(h_state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference datapath: 4x4 nibble multiply, shift, accumulate.
  logic [7:0]  a, b;
  logic [3:0]  a_n, b_n;
  logic [15:0] pp, acc;
  always_comb begin
    a_n = input_sel[1] ? a[7:4] : a[3:0];
    b_n = input_sel[0] ? b[7:4] : b[3:0];
    pp  = {8'h00, {4'h0, a_n} * {4'h0, b_n}};
    case (shift_sel)
      2'b01:   pp = pp << 4;
      2'b10:   pp = pp << 8;
      default: pp = pp;
    endcase
  end
  always @(posedge clk or posedge reset) begin
    if (reset)        acc <= 16'h0000;
    else if (acc_clr) acc <= pp;
    else if (acc_en)  acc <= acc + pp;
  end

  // {input_sel, shift_sel, acc_clr, acc_en, busy, done, err, state_out}
  logic [11:0] obs, obs_h;
  assign obs   = {input_sel, shift_sel, acc_clr, acc_en, busy, done, err, state_out};
  assign obs_h = {h_input_sel, h_shift_sel, h_acc_clr, h_acc_en, h_busy, h_done, h_err, h_state_out};

  localparam logic [11:0] E_IDLE  = {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
  localparam logic [11:0] E_LSB   = {2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
  localparam logic [11:0] E_MID1  = {2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2};
  localparam logic [11:0] E_MID2  = {2'b10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2};
  localparam logic [11:0] E_MSB   = {2'b11, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3};
  localparam logic [11:0] E_DONE  = {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
  localparam logic [11:0] E_ERR   = {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4};
  localparam logic [11:0] E_STALL = {2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
  localparam logic [11:0] DONE_M  = 12'h010;

  logic [11:0] e_seq [5];
  initial e_seq = '{E_LSB, E_MID1, E_MID2, E_MSB, E_DONE};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [11:0] e);
    #1;
    check(tag, obs, e);
    check({tag, "_h"}, obs_h & ~DONE_M, e & ~DONE_M);
  endtask

  // Pulses start (from IDLE or DONE) and walks the five-cycle sequence, ending in DONE.
  task automatic run_product(input string tag, input logic [7:0] av, input logic [7:0] bv,
                             input logic [15:0] prod);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("%s_c%0d", tag, i + 1), e_seq[i]);
      if (i == 0) check({tag, "_doneh_clr"}, h_done, 1'b0);
      if (i < 4) tick();
    end
    check({tag, "_prod"}, acc, prod);
    check({tag, "_doneh_set"}, h_done, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; en = 1'b1; a = 8'h00; b = 8'h00;
    #12;
    chk_out("reset", E_IDLE);
    check("reset_doneh", h_done, 1'b0);
    reset = 1'b0;

    tick();
    chk_out("idle", E_IDLE);
    run_product("p1", 8'hA7, 8'h3C, 16'h2724);
    tick();
    chk_out("p1_after", E_IDLE);

    // start held two cycles, then a restart attempt in MSB held two cycles
    start = 1'b1;
    tick();
    chk_out("hold_lsb", E_LSB);
    tick();
    start = 1'b0;
    chk_out("hold_err", E_ERR);
    tick();
    chk_out("hold_idle", E_IDLE);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk_out("rs_msb", E_MSB);
    start = 1'b1;
    tick();
    chk_out("rs_err", E_ERR);
    tick();
    chk_out("rs_err_stay", E_ERR);
    start = 1'b0;
    tick();
    chk_out("rs_idle", E_IDLE);

    // three stalled cycles in MID1, with a lost start during the stall
    a = 8'h12; b = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("st_lsb", E_LSB);
    tick();
    chk_out("st_mid1", E_MID1);
    en = 1'b0;
    chk_out("st_hold1", E_STALL);
    tick();
    start = 1'b1;
    chk_out("st_hold2", E_STALL);
    tick();
    start = 1'b0;
    chk_out("st_hold3", E_STALL);
    tick();
    en = 1'b1;
    chk_out("st_resume", E_MID1);
    tick();
    chk_out("st_mid2", E_MID2);
    tick();
    chk_out("st_msb", E_MSB);
    tick();
    chk_out("st_done_c8", E_DONE);
    check("st_prod", acc, 16'h03A8);
    tick();
    chk_out("st_idle", E_IDLE);

    // back-to-back products
    run_product("b2b1", 8'hA7, 8'h3C, 16'h2724);
    run_product("b2b2", 8'hFF, 8'hFF, 16'hFE01);
    tick();
    chk_out("b2b_idle", E_IDLE);

    // reset in MSB aborts at once and no done follows
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk_out("rst_msb", E_MSB);
    reset = 1'b1;
    chk_out("rst_now", E_IDLE);
    check("rst_doneh", h_done, 1'b0);
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("rst_post%0d", i), E_IDLE);
      check($sformatf("rst_post_doneh%0d", i), h_done, 1'b0);
    end

    // sticky done persists through idle and clears on the next accepted start
    run_product("dh", 8'h0F, 8'hF0, 16'h0E10);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out($sformatf("dh_idle%0d", i), E_IDLE);
      check($sformatf("dh_sticky%0d", i), h_done, 1'b1);
    end
    start = 1'b1;
    #1 check("dh_pre_accept", h_done, 1'b1);
    tick();
    start = 1'b0;
    chk_out("dh_lsb", E_LSB);
    check("dh_cleared", h_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult8x8_sequencer.md
# mult8x8_sequencer

Control FSM for the sequential 8x8 multiplier. It steps the shared 4x4 multiplier through the four nibble-pair partial products over four cycles and drives the operand-select mux, the shifter amount and the accumulator controls. It also raises `done`/`busy` and produces a 3-bit step code that feeds the seven-segment decoder directly: codes 0–3 display, 4–7 blank.

## Interface
- `DONE_HOLD`, default 0: 0 means `done` is a 1-cycle pulse; 1 means `done` stays high until the next accepted `start` or reset.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request; sampled only when `en`=1.
- `en` in 1: step enable; 0 freezes the FSM.
- `input_sel` out 2: nibble pair for the 4x4 multiplier. 00=a_lo·b_lo, 01=a_lo·b_hi, 10=a_hi·b_lo, 11=a_hi·b_hi.
- `shift_sel` out 2: shifter amount. 00=<<0, 01=<<4, 10=<<8, 11 unused (never driven).
- `acc_clr` out 1: load the accumulator with the shifted partial product, discarding the old value.
- `acc_en` out 1: add the shifted partial product into the accumulator.
- `busy` out 1: high from the LSB state through the MSB state.
- `done` out 1: product valid.
- `err` out 1: high while in the ERR state.
- `state_out` out 3: display code for the seven-segment decoder.

## Operation
- States: IDLE, LSB, MID1, MID2, MSB, DONE, ERR. State is a registered binary encoding.
- All outputs are Moore outputs decoded from the state register. They are gated by `en` as noted below.
- Per-state outputs, listed as (`input_sel`, `shift_sel`, `acc_clr`, `acc_en`, `state_out`):
  - IDLE: (00, 00, 0, 0, 0)
  - LSB: (00, 00, 1, 0, 1)
  - MID1: (01, 01, 0, 1, 2)
  - MID2: (10, 01, 0, 1, 2)
  - MSB: (11, 10, 0, 1, 3)
  - DONE: (00, 00, 0, 0, 0)
  - ERR: (00, 00, 0, 0, 4)
- Transitions apply only when `en`=1:
  - IDLE → LSB on `start`=1; otherwise stay in IDLE.
  - LSB → MID1 → MID2 → MSB → DONE, unconditionally when `start`=0.
  - `start`=1 in any of LSB, MID1, MID2 or MSB → ERR. This covers a held start and a restart attempt. The accumulator is not updated in the cycle the FSM enters ERR.
  - DONE → LSB if `start`=1 (back-to-back operation); otherwise → IDLE.
  - ERR → IDLE when `start`=0; stay in ERR while `start`=1.
- `en`=0: state holds and `acc_clr`/`acc_en` are forced to 0. `input_sel`, `shift_sel` and `state_out` hold their values. A `start` pulse that arrives while `en`=0 is lost.
- `done`:
  - `DONE_HOLD`=0: high only in the DONE state.
  - `DONE_HOLD`=1: a sticky flag. It is set on entry to DONE and cleared on accepted `start`, on entry to ERR, or on reset.
- Arithmetic note (datapath, for reference only): the accumulated result is a·b, 16 bits. The controller never inspects data.

## Timing
- Reset (asynchronous): state=IDLE. Outputs: `input_sel`=00, `shift_sel`=00, `acc_clr`=0, `acc_en`=0, `busy`=0, `done`=0, `err`=0, `state_out`=000.
- Reset mid-operation aborts immediately. No `done` is produced.
- Latency with `en` held at 1:
  - `start` sampled at edge 0.
  - LSB occupies cycle 1, MID1 cycle 2, MID2 cycle 3, MSB cycle 4.
  - DONE occupies cycle 5, and `done` is visible after edge 5.
  - Total: 5 cycles from start to done.
- Back-to-back: `start` asserted during DONE gives LSB in the next cycle. Throughput is one product per 5 cycles.
- Each cycle with `en`=0 adds exactly one cycle of latency.

## Structure
- Package `mult_seq_pkg` holds:
  - the state enum;
  - `input_sel` constants SEL_LL, SEL_LH, SEL_HL, SEL_HH;
  - `shift_sel` constants SH0, SH4, SH8;
  - display codes DISP_IDLE=0, DISP_LSB=1, DISP_MID=2, DISP_MSB=3, DISP_ERR=4.
- Single module; no sub-module. The next-state logic and the output decode are two processes in the same module.

## Test plan
- Reset, then one `start` pulse with `en`=1 → `input_sel` steps 00,01,10,11; `shift_sel` steps 00,01,01,10; `acc_clr` is high only in cycle 1; `done`=1 in cycle 5; `state_out` steps 1,2,2,3,0. With the datapath attached, a=0xA7, b=0x3C gives a product of 0x2724.
- `start` held high for 2 cycles → ERR in cycle 2, `state_out`=4, `err`=1, `acc_en`=0; the FSM returns to IDLE the cycle after `start` drops; `done` is never asserted.
- `en` dropped for 3 cycles during MID1 → state and selects hold, `acc_en`=0 during the stall, `done` arrives at cycle 8.
- `start` asserted during DONE → LSB follows immediately; the second product is correct (0xFF·0xFF=0xFE01).
- `reset` pulsed in MSB → outputs are all 0 within the same cycle, the FSM is in IDLE, and no `done` pulse follows.
- `DONE_HOLD`=1 → `done` stays high across 10 IDLE cycles and clears on the cycle the next `start` is accepted.
